// File: rtl/serial_addsub_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract sequencer.
// The master side issues operations; the slave side is the sequencer itself.
interface serial_addsub_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder/subtractor cell and a carry/borrow flop,
// LSB first, WIDTH cycles per operation, one-cycle done strobe.
module serial_addsub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  serial_addsub_ctrl_if.slave bus
);
  localparam int unsigned   CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic ai, bi, s, c_next;

  // Single shared cell: the sum and difference bits are identical, only the carry differs.
  always_comb begin
    ai = a_sh_q[0];
    bi = b_sh_q[0];
    s  = ai ^ bi ^ c_q;
    if (op_q) begin
      c_next = (~ai & bi) | (c_q & ~(ai ^ bi));
    end else begin
      c_next = (ai & bi) | (c_q & (ai ^ bi));
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    c_d      = c_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          op_d    = bus.op;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        acc_d  = {s, acc_q[WIDTH-1:1]};
        c_d    = c_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          // c_q here is the carry/borrow into the MSB.
          result_d = {s, acc_q[WIDTH-1:1]};
          cout_d   = c_next;
          ovf_d    = c_q ^ c_next;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = (state_q == StRun);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed vectors, random operations against an
// arithmetic reference model, held-start and mid-operation reset sequences.
module tb_serial_addsub_ctrl;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Packed {ovf, cout, result} from plain modular arithmetic.
  function automatic logic [WIDTH+1:0] model(input logic op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] r;
    logic             co, ov;
    if (!op) begin
      full = {1'b0, a} + {1'b0, b};
      r    = full[WIDTH-1:0];
      co   = full[WIDTH];
      ov   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end else begin
      r  = a - b;
      co = (a < b);
      ov = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
    return {ov, co, r};
  endfunction

  task automatic wait_done(output int lat, output int busy_cnt, output bit ok);
    lat      = 0;
    busy_cnt = 0;
    ok       = 1'b0;
    for (int i = 0; i < 4 * WIDTH; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      lat++;
      if (bus.busy) busy_cnt++;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the done cycle.
  task automatic run_op(input string tag, input logic op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, output logic [WIDTH+1:0] got);
    int lat, bc, b0;
    bit ok;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    b0        = int'(bus.busy);
    wait_done(lat, bc, ok);
    check({tag, " done seen"}, 32'(ok), 32'd1);
    check({tag, " latency"}, lat + 1, WIDTH);
    check({tag, " busy cycles"}, bc + b0, WIDTH);
    check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    got = {bus.ovf, bus.cout, bus.result};
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [WIDTH+1:0] got, exp, exp1, exp2;
    logic             rop;
    logic [WIDTH-1:0] ra, rb;
    int               lat, bc, b0, seen;
    bit               ok;

    vecs[0] = '{1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    check("reset cout", 32'(bus.cout), 32'd0);
    check("reset ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, got);
      check($sformatf("vec%0d result", i), 32'(got[WIDTH-1:0]), 32'(vecs[i].res));
      check($sformatf("vec%0d cout", i), 32'(got[WIDTH]), 32'(vecs[i].cout));
      check($sformatf("vec%0d ovf", i), 32'(got[WIDTH+1]), 32'(vecs[i].ovf));
    end

    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom);
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      exp = model(rop, ra, rb);
      run_op($sformatf("rand%0d", i), rop, ra, rb, got);
      check($sformatf("rand%0d op=%0d a=%0h b=%0h {ovf,cout,res}", i, rop, ra, rb),
            32'(got), 32'(exp));
    end

    // Start held high across a whole operation while operands change after acceptance.
    exp1      = model(1'b1, 8'h80, 8'h01);
    exp2      = model(1'b0, 8'h11, 8'h22);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 8'h80;
    bus.b     = 8'h01;
    @(negedge clk);
    bus.op = 1'b0;
    bus.a  = 8'h11;
    bus.b  = 8'h22;
    b0     = int'(bus.busy);
    wait_done(lat, bc, ok);
    check("hold first done seen", 32'(ok), 32'd1);
    check("hold first latency", lat + 1, WIDTH);
    check("hold first busy cycles", bc + b0, WIDTH);
    check("hold first result", 32'({bus.ovf, bus.cout, bus.result}), 32'(exp1));
    @(negedge clk);
    check("hold idle gap busy/done", 32'({bus.busy, bus.done}), 32'd0);
    @(negedge clk);
    check("hold second accepted", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done(lat, bc, ok);
    check("hold second done seen", 32'(ok), 32'd1);
    check("hold second latency", lat + 1, WIDTH);
    check("hold second result", 32'({bus.ovf, bus.cout, bus.result}), 32'(exp2));
    @(negedge clk);
    check("hold second done one cycle", 32'(bus.done), 32'd0);

    // Reset three cycles into an operation; previous result (0x33) must clear.
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 8'h55;
    bus.b     = 8'h22;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst result", 32'(bus.result), 32'd0);
    check("midrst cout/ovf", 32'({bus.cout, bus.ovf}), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("midrst no activity after abort", seen, 0);
    run_op("post-reset", 1'b0, 8'h10, 8'h20, got);
    check("post-reset result", 32'(got[WIDTH-1:0]), 32'h30);
    check("post-reset cout/ovf", 32'(got[WIDTH+1:WIDTH]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
